// File: rtl/bp_be_pkg.sv
// Shared backend types: processor config selector and the RPT scheduler prefetch FSM states.
package bp_be_pkg;

  typedef enum logic [0:0] {
    e_bp_default_cfg = 1'b0
  } bp_params_e;

  typedef enum logic [0:0] {
    e_idle  = 1'b0,
    e_burst = 1'b1
  } bp_be_rpt_sched_state_e;

  function automatic int vaddr_width_f(input bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return 39;
      default:          return 39;
    endcase
  endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small circular-buffer FIFO with valid/ready input, valid/yumi output and a synchronous clear.
module bsg_fifo_1r1w_small #(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);
  localparam logic [ptr_w_lp-1:0] last_lp = ptr_w_lp'(els_p - 1);
  localparam logic [cnt_w_lp-1:0] full_lp = cnt_w_lp'(els_p);

  logic [width_p-1:0]  mem_q [els_p];
  logic [ptr_w_lp-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [cnt_w_lp-1:0] cnt_q, cnt_d;
  logic                enq, deq;

  assign ready_o = (cnt_q != full_lp);
  assign v_o     = (cnt_q != '0);
  assign data_o  = mem_q[rptr_q];

  // Clear wins over any same-cycle push or pop.
  assign enq = v_i & ready_o & ~clear_i;
  assign deq = yumi_i & v_o & ~clear_i;

  always_comb begin
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      rptr_d = '0;
      wptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (enq) wptr_d = (wptr_q == last_lp) ? '0 : wptr_q + ptr_w_lp'(1);
      if (deq) rptr_d = (rptr_q == last_lp) ? '0 : rptr_q + ptr_w_lp'(1);
      if (enq & ~deq)      cnt_d = cnt_q + cnt_w_lp'(1);
      else if (deq & ~enq) cnt_d = cnt_q - cnt_w_lp'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/bp_be_rpt_sched.sv
// RPT scheduler: queues retired loads, issues one per cycle with same-set bubbling, expands stride hits
// into prefetch bursts.  state | meaning:  e_idle | no burst active;  e_burst | presenting base+k*stride
module bp_be_rpt_sched
  import bp_be_pkg::*;
#(
  parameter bp_params_e bp_params_p       = e_bp_default_cfg,
  parameter int         rpt_sets_p        = 32,
  parameter int         stride_width_p    = 8,
  parameter int         queue_els_p       = 4,
  parameter int         prefetch_degree_p = 2,
  localparam int        vaddr_width_p     = vaddr_width_f(bp_params_p)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      flush_i,

  input  logic                      ld_v_i,
  input  logic [vaddr_width_p-1:0]  ld_pc_i,
  input  logic [vaddr_width_p-1:0]  ld_eaddr_i,
  output logic                      ld_ready_and_o,

  input  logic                      rpt_init_done_i,
  output logic                      rpt_w_v_o,
  output logic [vaddr_width_p-1:0]  rpt_pc_o,
  output logic [vaddr_width_p-1:0]  rpt_eaddr_o,
  input  logic                      rpt_stride_v_i,
  input  logic [stride_width_p-1:0] rpt_stride_i,

  output logic                      pf_v_o,
  output logic [vaddr_width_p-1:0]  pf_vaddr_o,
  input  logic                      pf_yumi_i,
  output logic                      pf_drop_o
);

  localparam int         idx_width_lp = $clog2(rpt_sets_p);
  localparam logic [2:0] degree_lp    = 3'(prefetch_degree_p);

  logic                       fifo_v, fifo_ready;
  logic [2*vaddr_width_p-1:0] fifo_data;
  logic [vaddr_width_p-1:0]   head_pc, head_eaddr;
  logic                       hazard, issue;

  bsg_fifo_1r1w_small #(
    .width_p(2*vaddr_width_p),
    .els_p  (queue_els_p)
  ) queue (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clear_i(flush_i),
    .v_i    (ld_v_i),
    .ready_o(fifo_ready),
    .data_i ({ld_pc_i, ld_eaddr_i}),
    .v_o    (fifo_v),
    .data_o (fifo_data),
    .yumi_i (issue)
  );

  assign head_pc        = fifo_data[2*vaddr_width_p-1:vaddr_width_p];
  assign head_eaddr     = fifo_data[vaddr_width_p-1:0];
  assign ld_ready_and_o = fifo_ready & ~reset_i;

  logic                    prev_v_q;
  logic [idx_width_lp-1:0] prev_idx_q;

  // One bubble suffices: the bubble cycle itself clears prev_v_q.
  assign hazard = prev_v_q & (head_pc[idx_width_lp-1:0] == prev_idx_q);
  assign issue  = fifo_v & rpt_init_done_i & ~flush_i & ~reset_i & ~hazard;

  assign rpt_w_v_o   = issue;
  assign rpt_pc_o    = issue ? head_pc    : '0;
  assign rpt_eaddr_o = issue ? head_eaddr : '0;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prev_v_q   <= 1'b0;
      prev_idx_q <= '0;
    end else begin
      prev_v_q   <= issue;
      prev_idx_q <= head_pc[idx_width_lp-1:0];
    end
  end

  // Shadow pipe lines up each issued eaddr with the RPT result two cycles later.
  logic                     sh1_v_q, sh2_v_q;
  logic [vaddr_width_p-1:0] sh1_eaddr_q, sh2_eaddr_q;

  always_ff @(posedge clk_i) begin
    if (reset_i | flush_i) begin
      sh1_v_q     <= 1'b0;
      sh2_v_q     <= 1'b0;
      sh1_eaddr_q <= '0;
      sh2_eaddr_q <= '0;
    end else begin
      sh1_v_q     <= issue;
      sh1_eaddr_q <= head_eaddr;
      sh2_v_q     <= sh1_v_q;
      sh2_eaddr_q <= sh1_eaddr_q;
    end
  end

  logic                     hit;
  logic [vaddr_width_p-1:0] stride_ext;

  assign hit        = rpt_stride_v_i & sh2_v_q & ~flush_i;
  assign stride_ext = {{(vaddr_width_p-stride_width_p){rpt_stride_i[stride_width_p-1]}}, rpt_stride_i};

  bp_be_rpt_sched_state_e   state_q;
  logic [2:0]               k_q;
  logic [vaddr_width_p-1:0] stride_q, addr_q;
  logic                     pf_v_q, pf_drop_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= e_idle;
      k_q       <= 3'd0;
      stride_q  <= '0;
      addr_q    <= '0;
      pf_v_q    <= 1'b0;
      pf_drop_q <= 1'b0;
    end else begin
      pf_drop_q <= hit & (state_q == e_burst);
      if (flush_i) begin
        state_q <= e_idle;
        pf_v_q  <= 1'b0;
        addr_q  <= '0;
      end else begin
        case (state_q)
          e_idle: begin
            if (hit && (rpt_stride_i != '0)) begin
              state_q  <= e_burst;
              pf_v_q   <= 1'b1;
              k_q      <= 3'd1;
              stride_q <= stride_ext;
              addr_q   <= sh2_eaddr_q + stride_ext;
            end
          end
          e_burst: begin
            if (pf_yumi_i) begin
              if (k_q == degree_lp) begin
                state_q <= e_idle;
                pf_v_q  <= 1'b0;
                addr_q  <= '0;
              end else begin
                k_q    <= k_q + 3'd1;
                addr_q <= addr_q + stride_q;
              end
            end
          end
          default: begin
            state_q <= e_idle;
            pf_v_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pf_v_o     = pf_v_q & ~reset_i;
  assign pf_vaddr_o = pf_v_o ? addr_q : '0;
  assign pf_drop_o  = pf_drop_q & ~reset_i;

endmodule

// File: tb/tb_bp_be_rpt_sched.sv
// Bench for bp_be_rpt_sched: directed tables/sequences plus random traffic, all cross-checked every
// cycle against a queue-based reference model.
module tb_bp_be_rpt_sched;
  import bp_be_pkg::*;

  localparam int VW   = 39;
  localparam int SW   = 8;
  localparam int QE   = 4;
  localparam int DEG  = 2;
  localparam int IDXW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, flush, ld_v, init, sv, yumi;
  logic [VW-1:0] ld_pc, ld_ea;
  logic [SW-1:0] st;

  logic          ld_ready, rpt_w_v, pf_v, pf_drop;
  logic [VW-1:0] rpt_pc, rpt_ea, pf_vaddr;

  bp_be_rpt_sched dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .flush_i        (flush),
    .ld_v_i         (ld_v),
    .ld_pc_i        (ld_pc),
    .ld_eaddr_i     (ld_ea),
    .ld_ready_and_o (ld_ready),
    .rpt_init_done_i(init),
    .rpt_w_v_o      (rpt_w_v),
    .rpt_pc_o       (rpt_pc),
    .rpt_eaddr_o    (rpt_ea),
    .rpt_stride_v_i (sv),
    .rpt_stride_i   (st),
    .pf_v_o         (pf_v),
    .pf_vaddr_o     (pf_vaddr),
    .pf_yumi_i      (yumi),
    .pf_drop_o      (pf_drop)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: loads in a queue, issues remembered by cycle number, burst as base + k*stride.
  typedef struct packed {
    logic [VW-1:0] pc;
    logic [VW-1:0] ea;
  } ld_t;

  ld_t           mq[$];
  int            hcyc[$];
  logic [VW-1:0] hea[$];
  logic          m_last_v = 1'b0;
  logic [IDXW-1:0] m_last_idx = '0;
  logic          m_burst = 1'b0;
  logic [VW-1:0] m_base = '0, m_stride = '0;
  int            m_k = 0;
  logic          m_drop = 1'b0;
  logic          e_issue;
  ld_t           m_head;

  task automatic sample();
    logic          e_ready, e_pfv;
    logic [VW-1:0] e_pf;
    @(negedge clk);
    m_head  = (mq.size() > 0) ? mq[0] : '0;
    e_ready = !reset && (mq.size() < QE);
    e_issue = !reset && (mq.size() > 0) && init && !flush &&
              !(m_last_v && (m_head.pc[IDXW-1:0] == m_last_idx));
    e_pfv   = !reset && m_burst;
    e_pf    = e_pfv ? (m_base + VW'(m_k) * m_stride) : '0;
    chk("m_ready", ld_ready, e_ready);
    chk("m_rpt_w_v", rpt_w_v, e_issue);
    chk("m_rpt_pc", rpt_pc, e_issue ? m_head.pc : '0);
    chk("m_rpt_eaddr", rpt_ea, e_issue ? m_head.ea : '0);
    chk("m_pf_v", pf_v, e_pfv);
    chk("m_pf_vaddr", pf_vaddr, e_pf);
    chk("m_pf_drop", pf_drop, !reset && m_drop);
  endtask

  task automatic advance();
    logic          hitv;
    logic [VW-1:0] hb, sx;
    int            sz;
    if (reset) begin
      mq.delete(); hcyc.delete(); hea.delete();
      m_last_v = 1'b0; m_burst = 1'b0; m_drop = 1'b0;
    end else begin
      hitv = 1'b0;
      hb   = '0;
      sx   = {{(VW-SW){st[SW-1]}}, st};
      if (!flush && sv)
        foreach (hcyc[i]) if (hcyc[i] == cyc - 2) begin hitv = 1'b1; hb = hea[i]; end
      m_drop = hitv && m_burst;
      if (flush) m_burst = 1'b0;
      else if (m_burst) begin
        if (yumi) begin
          if (m_k == DEG) m_burst = 1'b0;
          else m_k++;
        end
      end else if (hitv && st != '0) begin
        m_burst = 1'b1; m_base = hb; m_stride = sx; m_k = 1;
      end
      sz = mq.size();
      if (flush) begin
        mq.delete(); hcyc.delete(); hea.delete();
      end else begin
        if (e_issue) begin
          hcyc.push_back(cyc);
          hea.push_back(m_head.ea);
          void'(mq.pop_front());
        end
        if (ld_v && sz < QE) mq.push_back('{pc: ld_pc, ea: ld_ea});
      end
      m_last_v   = e_issue;
      m_last_idx = m_head.pc[IDXW-1:0];
      while (hcyc.size() > 0 && hcyc[0] < cyc - 3) begin
        void'(hcyc.pop_front());
        void'(hea.pop_front());
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    reset = 1'b0; flush = 1'b0; ld_v = 1'b0; ld_pc = '0; ld_ea = '0;
    sv = 1'b0; st = '0; yumi = 1'b0;
  endtask

  task automatic load(input logic [VW-1:0] pc, input logic [VW-1:0] ea);
    ld_v = 1'b1; ld_pc = pc; ld_ea = ea;
  endtask

  typedef struct {
    logic          ldv;
    logic [VW-1:0] pc, ea;
    logic          sv;
    logic [SW-1:0] st;
    logic          y;
    logic          ewv;
    logic [VW-1:0] epc, eea;
    logic          epfv;
    logic [VW-1:0] epa;
  } vec_t;

  function automatic vec_t mk(input logic ldv, input longint pc, input longint ea, input logic sv_,
                              input longint st_, input logic y, input logic ewv, input longint epc,
                              input longint eea, input logic epfv, input longint epa);
    vec_t v;
    v.ldv = ldv; v.pc = VW'(pc); v.ea = VW'(ea); v.sv = sv_; v.st = SW'(st_); v.y = y;
    v.ewv = ewv; v.epc = VW'(epc); v.eea = VW'(eea); v.epfv = epfv; v.epa = VW'(epa);
    return v;
  endfunction

  vec_t tbl[24];

  initial begin
    // burst (+0x40), same-set hazard, different-set back-to-back, negative stride with backpressure
    tbl[0]  = mk(1, 'h100, 'h8000, 0, 0,    0, 0, 0,     0,      0, 0);
    tbl[1]  = mk(0, 0,     0,      0, 0,    0, 1, 'h100, 'h8000, 0, 0);
    tbl[2]  = mk(0, 0,     0,      0, 0,    0, 0, 0,     0,      0, 0);
    tbl[3]  = mk(0, 0,     0,      1, 'h40, 0, 0, 0,     0,      0, 0);
    tbl[4]  = mk(0, 0,     0,      0, 0,    1, 0, 0,     0,      1, 'h8040);
    tbl[5]  = mk(0, 0,     0,      0, 0,    1, 0, 0,     0,      1, 'h8080);
    tbl[6]  = mk(0, 0,     0,      0, 0,    0, 0, 0,     0,      0, 0);
    tbl[7]  = mk(1, 'h100, 'h10,   0, 0,    0, 0, 0,     0,      0, 0);
    tbl[8]  = mk(1, 'h100, 'h20,   0, 0,    0, 1, 'h100, 'h10,   0, 0);
    tbl[9]  = mk(0, 0,     0,      0, 0,    0, 0, 0,     0,      0, 0);
    tbl[10] = mk(0, 0,     0,      0, 0,    0, 1, 'h100, 'h20,   0, 0);
    tbl[11] = mk(1, 'h100, 'h30,   0, 0,    0, 0, 0,     0,      0, 0);
    tbl[12] = mk(1, 'h104, 'h40,   0, 0,    0, 1, 'h100, 'h30,   0, 0);
    tbl[13] = mk(0, 0,     0,      0, 0,    0, 1, 'h104, 'h40,   0, 0);
    tbl[14] = mk(1, 'h200, 'h1000, 0, 0,    0, 0, 0,     0,      0, 0);
    tbl[15] = mk(0, 0,     0,      0, 0,    0, 1, 'h200, 'h1000, 0, 0);
    tbl[16] = mk(0, 0,     0,      0, 0,    0, 0, 0,     0,      0, 0);
    tbl[17] = mk(0, 0,     0,      1, 'hF8, 0, 0, 0,     0,      0, 0);
    tbl[18] = mk(0, 0,     0,      0, 0,    0, 0, 0,     0,      1, 'hFF8);
    tbl[19] = mk(0, 0,     0,      0, 0,    0, 0, 0,     0,      1, 'hFF8);
    tbl[20] = mk(0, 0,     0,      0, 0,    0, 0, 0,     0,      1, 'hFF8);
    tbl[21] = mk(0, 0,     0,      0, 0,    1, 0, 0,     0,      1, 'hFF8);
    tbl[22] = mk(0, 0,     0,      0, 0,    1, 0, 0,     0,      1, 'hFF0);
    tbl[23] = mk(0, 0,     0,      0, 0,    0, 0, 0,     0,      0, 0);

    set_idle();
    init = 1'b0;
    @(posedge clk);
    #1;

    // reset: everything low, including ready
    reset = 1'b1; ld_v = 1'b1; ld_pc = 39'h40; ld_ea = 39'h80;
    for (int i = 0; i < 2; i++) begin
      sample();
      chk("rst_ready", ld_ready, 1'b0);
      chk("rst_pf_v", pf_v, 1'b0);
      advance();
    end
    set_idle();
    sample();
    chk("post_rst_ready", ld_ready, 1'b1);
    chk("post_rst_w_v", rpt_w_v, 1'b0);
    advance();

    // init gating: fill the queue with init low, 5th offer is lost
    for (int i = 0; i < 5; i++) begin
      set_idle();
      load(VW'((i + 1) * 'h10), VW'('hA0 + i));
      sample();
      chk("init_ready", ld_ready, (i < 4) ? 1'b1 : 1'b0);
      chk("init_no_issue", rpt_w_v, 1'b0);
      advance();
    end
    set_idle();
    init = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sample();
      chk("init_issue_v", rpt_w_v, (i < 4) ? 1'b1 : 1'b0);
      chk("init_issue_pc", rpt_pc, (i < 4) ? VW'((i + 1) * 'h10) : '0);
      advance();
    end

    for (int i = 0; i < 24; i++) begin
      set_idle();
      ld_v = tbl[i].ldv; ld_pc = tbl[i].pc; ld_ea = tbl[i].ea;
      sv = tbl[i].sv; st = tbl[i].st; yumi = tbl[i].y;
      sample();
      chk($sformatf("tbl%0d_w_v", i), rpt_w_v, tbl[i].ewv);
      chk($sformatf("tbl%0d_pc", i), rpt_pc, tbl[i].epc);
      chk($sformatf("tbl%0d_eaddr", i), rpt_ea, tbl[i].eea);
      chk($sformatf("tbl%0d_pf_v", i), pf_v, tbl[i].epfv);
      chk($sformatf("tbl%0d_pf_vaddr", i), pf_vaddr, tbl[i].epa);
      advance();
    end

    // second hit during a burst is dropped, burst continues unchanged
    set_idle(); load(39'h400, 39'h2000); sample(); advance();
    set_idle(); load(39'h404, 39'h3000); sample(); advance();
    set_idle(); sample(); advance();
    set_idle(); sv = 1'b1; st = 8'h10; sample(); advance();
    set_idle(); sv = 1'b1; st = 8'h10; sample();
    chk("drop_pf_first", pf_vaddr, 39'h2010); advance();
    set_idle(); sample();
    chk("drop_pulse", pf_drop, 1'b1);
    chk("drop_pf_held", pf_vaddr, 39'h2010); advance();
    set_idle(); yumi = 1'b1; sample();
    chk("drop_pulse_end", pf_drop, 1'b0); advance();
    set_idle(); yumi = 1'b1; sample();
    chk("drop_pf_second", pf_vaddr, 39'h2020); advance();
    set_idle(); sample();
    chk("drop_idle", pf_v, 1'b0); advance();

    // zero stride hit produces nothing
    set_idle(); load(39'h500, 39'h6000); sample(); advance();
    set_idle(); sample(); chk("zero_issue", rpt_w_v, 1'b1); advance();
    set_idle(); sample(); advance();
    set_idle(); sv = 1'b1; st = 8'h00; sample(); advance();
    for (int i = 0; i < 3; i++) begin
      set_idle(); sample(); chk("zero_no_pf", pf_v, 1'b0); advance();
    end

    // flush with 3 queued loads, one RPT op in flight and a burst active
    init = 1'b0;
    set_idle(); load(39'h300, 39'h4000); sample(); advance();
    set_idle(); load(39'h304, 39'h5000); sample(); advance();
    set_idle(); load(39'h010, 39'h11);   sample(); advance();
    set_idle(); load(39'h014, 39'h12);   sample(); advance();
    init = 1'b1;
    set_idle(); sample(); chk("fl_issue_x", rpt_pc, 39'h300); advance();
    init = 1'b0;
    set_idle(); load(39'h018, 39'h13); sample(); chk("fl_ready", ld_ready, 1'b1); advance();
    init = 1'b1;
    set_idle(); sv = 1'b1; st = 8'h08; sample(); chk("fl_issue_y", rpt_pc, 39'h304); advance();
    init = 1'b0;
    set_idle(); flush = 1'b1; yumi = 1'b1; sample();
    chk("fl_burst_active", pf_vaddr, 39'h4008); advance();
    set_idle(); sv = 1'b1; st = 8'h10; sample();
    chk("fl_pf_off", pf_v, 1'b0);
    chk("fl_ready_after", ld_ready, 1'b1); advance();
    init = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_idle(); sample();
      chk("fl_no_pf", pf_v, 1'b0);
      chk("fl_queue_empty", rpt_w_v, 1'b0);
      advance();
    end

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      set_idle();
      reset = ($urandom_range(0, 299) == 0);
      flush = ($urandom_range(0, 59) == 0);
      init  = ($urandom_range(0, 9) != 0);
      ld_v  = $urandom_range(0, 1);
      ld_pc = VW'($urandom_range(0, 15)) << 2;
      ld_ea = {7'($urandom), 32'($urandom)};
      sv    = ($urandom_range(0, 2) == 0);
      st    = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      yumi  = m_burst && !reset && ($urandom_range(0, 2) != 0);
      sample();
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
